weight_demux: RTL

- Inverse of the outlier-packing weight mux in the weight path.
- Takes 8 packed 8-bit lanes plus the outlier sideband (sel, addr) and restores the original 8 x 4-bit weights.
  - The outlier nibble sits in the high nibble of lane addr[5:3].
  - It is written back into lane addr[2:0].
- Sits between the packed-weight buffer and the PE array feed.
- 2-stage valid/ready pipeline with full backpressure, and a saturating outlier counter for profiling.

---
 rtl/weight_demux_if.sv | 33 +++
 rtl/weight_demux.sv | 139 +++++++++++++
 2 files changed

// File: rtl/weight_demux_if.sv
// Packed-weight in / restored-weight out handshake bundle for weight_demux,
// plus the profiling counter and error sideband.
interface weight_demux_if #(
   parameter int unsigned LANES = 8,
   parameter int unsigned NIB   = 4,
   parameter int unsigned CNT_W = 16
);
   localparam int unsigned LW = $clog2(LANES);

   logic                      in_valid;
   logic                      in_ready;
   logic [LANES*2*NIB-1:0]    packed_i;
   logic                      sel_i;
   logic [2*LW-1:0]           addr_i;
   logic                      out_valid;
   logic                      out_ready;
   logic [LANES*NIB-1:0]      weight_o;
   logic                      sel_o;
   logic [2*LW-1:0]           addr_o;
   logic                      cnt_clr;
   logic [CNT_W-1:0]          outlier_cnt;
   logic                      err_o;

   modport master (
      output in_valid, packed_i, sel_i, addr_i, out_ready, cnt_clr,
      input  in_ready, out_valid, weight_o, sel_o, addr_o, outlier_cnt, err_o
   );

   modport slave (
      input  in_valid, packed_i, sel_i, addr_i, out_ready, cnt_clr,
      output in_ready, out_valid, weight_o, sel_o, addr_o, outlier_cnt, err_o
   );
endinterface

// File: rtl/weight_demux.sv
// Restores outlier-packed 8-bit lanes to 4-bit weights through a 2-stage valid/ready pipe.
// Optional sticky protocol checker enabled by defining WDEMUX_ERR_CHK_EN.
module weight_demux #(
   parameter int unsigned LANES = 8,
   parameter int unsigned NIB   = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   weight_demux_if.slave   bus
);
   localparam int unsigned LW = $clog2(LANES);
   localparam int unsigned PW = 2 * NIB;
   localparam int unsigned WW = LANES * NIB;
   localparam int unsigned AW = 2 * LW;

   logic            rdy_en;
   logic            s1_v, s2_v, s1_load, s2_load;
   logic [WW-1:0]   in_low, s1_low, dec_w, s2_w;
   logic [NIB-1:0]  in_cut, s1_cut;
   logic            s1_sel, s2_sel;
   logic [AW-1:0]   s1_addr, s2_addr;
   logic [CNT_W-1:0] cnt;

   // Hold in_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_en <= 1'b0;
      else        rdy_en <= 1'b1;
   end

   assign s2_load     = !s2_v || bus.out_ready;
   assign s1_load     = !s1_v || s2_load;
   assign bus.in_ready = rdy_en && s1_load;

   // Split incoming lanes into low nibbles and the carrier's high nibble
   always_comb begin
      in_low = '0;
      in_cut = '0;
      for (int j = 0; j < int'(LANES); j++) begin
         in_low[j*NIB +: NIB] = bus.packed_i[j*PW +: NIB];
         if (bus.addr_i[AW-1:LW] == LW'(j))
            in_cut = bus.packed_i[j*PW+NIB +: NIB];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v    <= 1'b0;
         s1_low  <= '0;
         s1_cut  <= '0;
         s1_sel  <= 1'b0;
         s1_addr <= '0;
      end else if (bus.in_ready) begin
         s1_v <= bus.in_valid;
         if (bus.in_valid) begin
            s1_low  <= in_low;
            s1_cut  <= in_cut;
            s1_sel  <= bus.sel_i;
            s1_addr <= bus.addr_i;
         end
      end
   end

   // Source lane takes the outlier nibble when sel is set
   always_comb begin
      dec_w = s1_low;
      for (int j = 0; j < int'(LANES); j++) begin
         if (s1_sel && (s1_addr[LW-1:0] == LW'(j)))
            dec_w[j*NIB +: NIB] = s1_cut;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v    <= 1'b0;
         s2_w    <= '0;
         s2_sel  <= 1'b0;
         s2_addr <= '0;
      end else if (s2_load) begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_w    <= dec_w;
            s2_sel  <= s1_sel;
            s2_addr <= s1_addr;
         end
      end
   end

   assign bus.out_valid   = s2_v;
   assign bus.weight_o    = s2_w;
   assign bus.sel_o       = s2_sel;
   assign bus.addr_o      = s2_addr;
   assign bus.outlier_cnt = cnt;

   // Saturating outlier counter; clear wins over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (bus.cnt_clr)
         cnt <= '0;
      else if (s2_v && bus.out_ready && s2_sel && (cnt != {CNT_W{1'b1}}))
         cnt <= cnt + CNT_W'(1);
   end

`ifdef WDEMUX_ERR_CHK_EN
   logic in_bad, s1_bad, s2_bad, err_r;

   // Flag stray high nibbles outside the carrier, or a dirty source low nibble
   always_comb begin
      in_bad = 1'b0;
      for (int j = 0; j < int'(LANES); j++) begin
         if ((bus.packed_i[j*PW+NIB +: NIB] != '0) &&
             !(bus.sel_i && (bus.addr_i[AW-1:LW] == LW'(j))))
            in_bad = 1'b1;
         if (bus.sel_i && (bus.addr_i[LW-1:0] == LW'(j)) &&
             (bus.packed_i[j*PW +: NIB] != '0))
            in_bad = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_bad <= 1'b0;
         s2_bad <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         if (bus.in_ready && bus.in_valid) s1_bad <= in_bad;
         if (s2_load && s1_v)              s2_bad <= s1_bad;
         if (bus.cnt_clr)                        err_r <= 1'b0;
         else if (s2_v && bus.out_ready && s2_bad) err_r <= 1'b1;
      end
   end

   assign bus.err_o = err_r;
`else
   assign bus.err_o = 1'b0;
`endif

endmodule
